// File: rtl/bypass_pkg.sv
// ---------------------------------------------------------------------------
// bypass_pkg
// Shared types and helpers for the hazard/bypass controller.
//   entry_t        : one in-flight producer {valid, we, dest, is_load}
//   SEL_RF         : forward select meaning "use the register file value"
//   sel_for_stage  : forward select for a producer found at tracker slot j
// Register addresses are stored zero-extended to MAX_RA_W bits so the entry
// type does not depend on the RA_W parameter of the instantiating block;
// RA_W must therefore not exceed MAX_RA_W.
// ---------------------------------------------------------------------------
package bypass_pkg;

   localparam int MAX_RA_W = 8;
   localparam int SEL_RF   = 0;

   typedef struct packed {
      logic                valid;
      logic                we;
      logic [MAX_RA_W-1:0] dest;
      logic                is_load;
   } entry_t;

   // A producer at tracker slot j sits in post-Execute stage j once the
   // consumer reaches Execute; stage k is selected with value k+1.
   function automatic int sel_for_stage(input int j);
      return j + 1;
   endfunction

endpackage

// File: rtl/bypass_ctrl_if.sv
// ---------------------------------------------------------------------------
// bypass_ctrl_if
// Decode-side bundle between the pipeline and the bypass controller.
//   id_valid/id_src_addr/id_src_used/id_dest_addr/id_dest_we/id_is_load :
//                 instruction currently in Decode (operand 0 in the LSBs)
//   flush       : redirect, kills the Decode instruction
//   mem_busy    : data memory busy, freezes the whole pipe
//   stall_fd    : hold PC and Decode
//   bubble_dx   : load a NOP into D/X
//   fwd_sel     : per-operand Execute mux select (0 = register file)
// Handshake: there is no valid/ready pair here; Decode advances on every
// rising clock edge where stall_fd is low, and D/X takes a bubble instead of
// the Decode instruction whenever bubble_dx is high.
// master = pipeline/Decode side, slave = bypass_ctrl.
// ---------------------------------------------------------------------------
interface bypass_ctrl_if #(
   parameter int NUM_SRC = 2,
   parameter int RA_W    = 5,
   parameter int SEL_W   = 2
) ();

   logic                      id_valid;
   logic [NUM_SRC*RA_W-1:0]   id_src_addr;
   logic [NUM_SRC-1:0]        id_src_used;
   logic [RA_W-1:0]           id_dest_addr;
   logic                      id_dest_we;
   logic                      id_is_load;
   logic                      flush;
   logic                      mem_busy;
   logic                      stall_fd;
   logic                      bubble_dx;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel;

   modport master (
      output id_valid, id_src_addr, id_src_used, id_dest_addr, id_dest_we,
             id_is_load, flush, mem_busy,
      input  stall_fd, bubble_dx, fwd_sel
   );

   modport slave (
      input  id_valid, id_src_addr, id_src_used, id_dest_addr, id_dest_we,
             id_is_load, flush, mem_busy,
      output stall_fd, bubble_dx, fwd_sel
   );

endinterface

// File: rtl/bypass_ctrl_inflight_pipe.sv
// ---------------------------------------------------------------------------
// inflight_pipe
// Shift register of in-flight producers. Slot 0 is the instruction in
// Execute, slot DEPTH-1 the oldest still tracked.
//   clock    : pipeline clock
//   reset_n  : asynchronous active-low reset, empties every slot
//   advance  : pipe moves this edge (low while memory is busy)
//   ins      : entry loaded into slot 0 on an advance (already invalid for
//              bubbles, flushes and empty Decode slots)
//   ent      : current contents of all slots
// ---------------------------------------------------------------------------
module inflight_pipe
   import bypass_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   advance,
   input  entry_t                 ins,
   output entry_t [DEPTH-1:0]     ent
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ent <= '0;
      end else if (advance) begin
         ent[0] <= ins;
         for (int p = 1; p < DEPTH; p++) begin
            ent[p] <= ent[p-1];
         end
      end
   end

endmodule

// File: rtl/bypass_ctrl.sv
// ---------------------------------------------------------------------------
// bypass_ctrl
// Hazard and bypass controller sitting between Decode and D/X.
//   clock        : pipeline clock
//   reset_n      : asynchronous active-low reset
//   bus          : Decode-side bundle (slave modport), see bypass_ctrl_if
//   stall_count  : saturating count of load-use bubble cycles
// For every source operand of the Decode instruction the youngest matching
// in-flight producer decides the forward select (registered for Execute)
// and whether a load result is still too far away, in which case Fetch and
// Decode stall and a bubble enters D/X.
// ---------------------------------------------------------------------------
module bypass_ctrl
   import bypass_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int LOAD_STAGE = 1,
   parameter int RA_W       = 5,
   parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
   input  logic                clock,
   input  logic                reset_n,
   bypass_ctrl_if.slave        bus,
   output logic [15:0]         stall_count
);

   localparam int DEPTH = FWD_STAGES + 1;

   entry_t [DEPTH-1:0]         ent;
   entry_t                     ins;
   logic                       advance;
   logic                       load_use;
   logic                       lu_eff;
   logic [NUM_SRC*SEL_W-1:0]   sel_next;
   logic [NUM_SRC*SEL_W-1:0]   fwd_q;

   // Match/priority: scan oldest to youngest so the youngest match is the
   // one left standing.
   always_comb begin
      int                  hit_p;
      logic                hit_ld;
      logic [MAX_RA_W-1:0] addr;
      load_use = 1'b0;
      sel_next = '0;
      hit_p    = -1;
      hit_ld   = 1'b0;
      addr     = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         hit_p  = -1;
         hit_ld = 1'b0;
         addr   = MAX_RA_W'(bus.id_src_addr[s*RA_W +: RA_W]);
         for (int p = DEPTH - 1; p >= 0; p--) begin
            if (ent[p].valid && ent[p].we && (ent[p].dest == addr) &&
                (addr != '0) && bus.id_src_used[s]) begin
               hit_p  = p;
               hit_ld = ent[p].is_load;
            end
         end
         if (hit_p >= 0) begin
            // A producer in the last slot writes back this cycle; the
            // register file is write-through, so no forwarding is needed.
            if (hit_p < FWD_STAGES) begin
               sel_next[s*SEL_W +: SEL_W] = SEL_W'(sel_for_stage(hit_p));
            end
            if (hit_ld && (hit_p < LOAD_STAGE)) begin
               load_use = 1'b1;
            end
         end
      end
   end

   assign lu_eff  = load_use & bus.id_valid & ~bus.flush;
   assign advance = ~bus.mem_busy;

   // mem_busy freezes everything, so D/X is not loaded with a bubble then.
   assign bus.stall_fd  = reset_n & (bus.mem_busy | lu_eff);
   assign bus.bubble_dx = reset_n & lu_eff & ~bus.mem_busy;
   assign bus.fwd_sel   = fwd_q;

   always_comb begin
      ins         = '0;
      ins.valid   = bus.id_valid & ~bus.flush & ~bus.bubble_dx;
      ins.we      = bus.id_dest_we;
      ins.dest    = MAX_RA_W'(bus.id_dest_addr);
      ins.is_load = bus.id_is_load;
   end

   inflight_pipe #(
      .DEPTH (DEPTH)
   ) u_pipe (
      .clock   (clock),
      .reset_n (reset_n),
      .advance (advance),
      .ins     (ins),
      .ent     (ent)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fwd_q <= '0;
      end else if (advance) begin
         fwd_q <= ins.valid ? sel_next : '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
      end else if (advance && bus.bubble_dx && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_bypass_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bypass_ctrl
// Drives two controllers with identical Decode streams: dut_a with the
// default configuration (FWD_STAGES=2, LOAD_STAGE=1) and dut_b with
// FWD_STAGES=3, LOAD_STAGE=2. A reference model keeps, per configuration,
// the list of recently issued instructions and derives the expected stall,
// bubble, forward select and bubble count from the hazard rules.
// ---------------------------------------------------------------------------
module tb_bypass_ctrl;

   typedef struct packed {
      logic       valid;
      logic [4:0] src1;
      logic [4:0] src0;
      logic [1:0] used;
      logic [4:0] dest;
      logic       we;
      logic       ld;
   } instr_t;

   typedef struct packed {
      logic       valid;
      logic       we;
      logic [4:0] dest;
      logic       ld;
   } m_ent_t;

   typedef struct packed {
      logic       lu;
      logic [1:0] s1;
      logic [1:0] s0;
   } m_res_t;

   typedef struct packed {
      instr_t      in;
      logic        fl;
      logic        busy;
      logic        stall;
      logic        bub;
      logic [3:0]  fwd;
      logic [15:0] cnt;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   bypass_ctrl_if #(.NUM_SRC(2), .RA_W(5), .SEL_W(2)) bus_a ();
   bypass_ctrl_if #(.NUM_SRC(2), .RA_W(5), .SEL_W(2)) bus_b ();
   logic [15:0] cnt_a;
   logic [15:0] cnt_b;

   bypass_ctrl dut_a (
      .clock       (clock),
      .reset_n     (reset_n),
      .bus         (bus_a),
      .stall_count (cnt_a)
   );

   bypass_ctrl #(.FWD_STAGES(3), .LOAD_STAGE(2)) dut_b (
      .clock       (clock),
      .reset_n     (reset_n),
      .bus         (bus_b),
      .stall_count (cnt_b)
   );

   logic        act_stall [2];
   logic        act_bub   [2];
   logic [3:0]  act_fwd   [2];
   logic [15:0] act_cnt   [2];
   assign act_stall[0] = bus_a.stall_fd;
   assign act_stall[1] = bus_b.stall_fd;
   assign act_bub[0]   = bus_a.bubble_dx;
   assign act_bub[1]   = bus_b.bubble_dx;
   assign act_fwd[0]   = bus_a.fwd_sel;
   assign act_fwd[1]   = bus_b.fwd_sel;
   assign act_cnt[0]   = cnt_a;
   assign act_cnt[1]   = cnt_b;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   int          cfg_f [2] = '{2, 3};
   int          cfg_l [2] = '{1, 2};
   m_ent_t      hist  [2][4];
   logic [3:0]  exp_q_a[$];
   logic [3:0]  exp_q_b[$];
   logic [3:0]  cur_fwd [2];
   logic [15:0] m_cnt   [2];
   logic        obs_stall [2];
   logic        obs_bub   [2];
   logic [3:0]  obs_fwd   [2];
   logic [15:0] obs_cnt   [2];
   vec_t        tbl [17];
   instr_t      nop_i = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic instr_t alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
      instr_t i;
      i = '0;
      i.valid = 1'b1; i.src0 = a; i.src1 = b; i.used = 2'b11; i.dest = d; i.we = 1'b1;
      return i;
   endfunction

   function automatic instr_t ldw(input logic [4:0] d, input logic [4:0] base);
      instr_t i;
      i = '0;
      i.valid = 1'b1; i.src0 = base; i.used = 2'b01; i.dest = d; i.we = 1'b1; i.ld = 1'b1;
      return i;
   endfunction

   // Most recent writer of each source decides; slot j is j issue slots ago.
   function automatic m_res_t model_eval(input int k, input instr_t in);
      m_res_t     r;
      logic [4:0] addr;
      int         found;
      r = '0;
      for (int s = 0; s < 2; s++) begin
         addr  = (s == 0) ? in.src0 : in.src1;
         found = -1;
         if (in.used[s] && addr != 5'd0) begin
            for (int j = 0; j <= cfg_f[k]; j++) begin
               if (found < 0 && hist[k][j].valid && hist[k][j].we && hist[k][j].dest == addr)
                  found = j;
            end
         end
         if (found >= 0) begin
            if (found < cfg_f[k]) begin
               if (s == 0) r.s0 = 2'(found + 1);
               else        r.s1 = 2'(found + 1);
            end
            if (hist[k][found].ld && found < cfg_l[k] && in.valid) r.lu = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic string tag(input string base, input int k);
      return $sformatf("%s_%s", base, (k == 0) ? "a" : "b");
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) hist[k][j] = '0;
         cur_fwd[k] = '0;
         m_cnt[k]   = '0;
      end
      exp_q_a.delete();
      exp_q_b.delete();
   endtask

   // ---------------- driver ----------------
   task automatic drive(input instr_t in, input logic fl, input logic busy);
      bus_a.id_valid = in.valid;       bus_b.id_valid = in.valid;
      bus_a.id_src_addr = {in.src1, in.src0};
      bus_b.id_src_addr = {in.src1, in.src0};
      bus_a.id_src_used = in.used;     bus_b.id_src_used = in.used;
      bus_a.id_dest_addr = in.dest;    bus_b.id_dest_addr = in.dest;
      bus_a.id_dest_we = in.we;        bus_b.id_dest_we = in.we;
      bus_a.id_is_load = in.ld;        bus_b.id_is_load = in.ld;
      bus_a.flush = fl;                bus_b.flush = fl;
      bus_a.mem_busy = busy;           bus_b.mem_busy = busy;
   endtask

   // One pipeline cycle: drive at the falling edge, check both DUTs against
   // the model, then advance the model for the coming rising edge.
   task automatic cycle(input instr_t in, input logic fl, input logic busy);
      m_res_t r;
      logic   e_stall, e_bub, iv;
      @(negedge clock);
      drive(in, fl, busy);
      #1;
      for (int k = 0; k < 2; k++) begin
         r       = model_eval(k, in);
         e_stall = busy | (r.lu & ~fl);
         e_bub   = r.lu & ~fl & ~busy;
         if (k == 0) begin
            if (exp_q_a.size() > 0) cur_fwd[0] = exp_q_a.pop_front();
         end else begin
            if (exp_q_b.size() > 0) cur_fwd[1] = exp_q_b.pop_front();
         end
         chk(tag("mdl_stall", k), 32'(act_stall[k]), 32'(e_stall));
         chk(tag("mdl_bubble", k), 32'(act_bub[k]), 32'(e_bub));
         chk(tag("mdl_fwd", k), 32'(act_fwd[k]), 32'(cur_fwd[k]));
         chk(tag("mdl_count", k), 32'(act_cnt[k]), 32'(m_cnt[k]));
         obs_stall[k] = act_stall[k];
         obs_bub[k]   = act_bub[k];
         obs_fwd[k]   = act_fwd[k];
         obs_cnt[k]   = act_cnt[k];
         if (!busy) begin
            iv = in.valid & ~fl & ~e_bub;
            for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = '{iv, in.we, in.dest, in.ld};
            if (k == 0) exp_q_a.push_back(iv ? {r.s1, r.s0} : 4'h0);
            else        exp_q_b.push_back(iv ? {r.s1, r.s0} : 4'h0);
            if (e_bub && m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
         end
      end
   endtask

   // Asserts reset with memory busy held (outputs must still read 0), then
   // releases it with an empty Decode slot.
   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      bus_a.mem_busy = 1'b1;
      bus_b.mem_busy = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk(tag("rst_stall", k), 32'(act_stall[k]), 32'd0);
         chk(tag("rst_bubble", k), 32'(act_bub[k]), 32'd0);
         chk(tag("rst_fwd", k), 32'(act_fwd[k]), 32'd0);
         chk(tag("rst_count", k), 32'(act_cnt[k]), 32'd0);
      end
      model_reset();
      drive(nop_i, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // ---------------- test ----------------
   initial begin
      int          n;
      logic [15:0] base;
      instr_t      use_i;
      instr_t      ri;

      drive(nop_i, 1'b0, 1'b0);
      model_reset();
      use_i = alu(5'd4, 5'd2, 5'd1);

      //             instr               fl    busy  stall bub   fwd    cnt
      tbl[0]  = '{alu(5'd3,5'd1,5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
      tbl[1]  = '{alu(5'd4,5'd3,5'd3), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
      tbl[2]  = '{nop_i,               1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 16'd0};
      tbl[3]  = '{alu(5'd3,5'd1,5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
      tbl[4]  = '{nop_i,               1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
      tbl[5]  = '{alu(5'd5,5'd3,5'd1), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
      tbl[6]  = '{nop_i,               1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 16'd0};
      tbl[7]  = '{ldw(5'd2,5'd1),      1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
      tbl[8]  = '{use_i,               1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 16'd0};
      tbl[9]  = '{use_i,               1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd1};
      tbl[10] = '{nop_i,               1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 16'd1};
      tbl[11] = '{alu(5'd0,5'd1,5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd1};
      tbl[12] = '{alu(5'd6,5'd0,5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd1};
      tbl[13] = '{nop_i,               1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd1};
      tbl[14] = '{ldw(5'd2,5'd1),      1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd1};
      tbl[15] = '{use_i,               1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd1};
      tbl[16] = '{nop_i,               1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd1};

      do_reset();

      // Directed vectors, expectations for the default configuration.
      for (int i = 0; i < 17; i++) begin
         cycle(tbl[i].in, tbl[i].fl, tbl[i].busy);
         chk($sformatf("tbl%0d_stall", i), 32'(obs_stall[0]), 32'(tbl[i].stall));
         chk($sformatf("tbl%0d_bubble", i), 32'(obs_bub[0]), 32'(tbl[i].bub));
         chk($sformatf("tbl%0d_fwd", i), 32'(obs_fwd[0]), 32'(tbl[i].fwd));
         chk($sformatf("tbl%0d_count", i), 32'(obs_cnt[0]), 32'(tbl[i].cnt));
      end

      // Deeper configuration: load-use costs two bubbles, then M/W+1 select.
      repeat (4) cycle(nop_i, 1'b0, 1'b0);
      base = m_cnt[1];
      cycle(ldw(5'd2, 5'd1), 1'b0, 1'b0);
      n = 0;
      for (int k = 0; k < 3; k++) begin
         cycle(use_i, 1'b0, 1'b0);
         if (obs_stall[1]) n++;
      end
      cycle(nop_i, 1'b0, 1'b0);
      chk("deep_stall_cycles", 32'(n), 32'd2);
      chk("deep_fwd", 32'(obs_fwd[1]), 32'h3);
      chk("deep_count", 32'(obs_cnt[1]), 32'(base + 16'd2));

      // Memory busy during a load-use stall: 3 frozen cycles plus 1 bubble.
      repeat (4) cycle(nop_i, 1'b0, 1'b0);
      base = m_cnt[0];
      cycle(ldw(5'd2, 5'd1), 1'b0, 1'b0);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(use_i, 1'b0, k < 3);
         if (obs_stall[0]) n++;
         else break;
      end
      cycle(nop_i, 1'b0, 1'b0);
      chk("busy_stall_cycles", 32'(n), 32'd4);
      chk("busy_fwd", 32'(obs_fwd[0]), 32'h2);
      chk("busy_count", 32'(obs_cnt[0]), 32'(base + 16'd1));

      // Reset in the middle of a load-use stall empties the tracker.
      repeat (4) cycle(nop_i, 1'b0, 1'b0);
      cycle(ldw(5'd2, 5'd1), 1'b0, 1'b0);
      cycle(use_i, 1'b0, 1'b0);
      chk("pre_reset_stall", 32'(obs_stall[0]), 32'd1);
      do_reset();
      cycle(use_i, 1'b0, 1'b0);
      chk("post_reset_stall_a", 32'(obs_stall[0]), 32'd0);
      chk("post_reset_stall_b", 32'(obs_stall[1]), 32'd0);
      cycle(nop_i, 1'b0, 1'b0);
      chk("post_reset_fwd_a", 32'(obs_fwd[0]), 32'd0);
      chk("post_reset_fwd_b", 32'(obs_fwd[1]), 32'd0);

      // Random traffic over a small register set to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         ri       = '0;
         ri.valid = ($urandom_range(0, 3) != 0);
         ri.src0  = 5'($urandom_range(0, 3));
         ri.src1  = 5'($urandom_range(0, 3));
         ri.used  = 2'($urandom_range(0, 3));
         ri.dest  = 5'($urandom_range(0, 3));
         ri.we    = ($urandom_range(0, 3) != 0);
         ri.ld    = ($urandom_range(0, 2) == 0);
         cycle(ri, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
